uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO. Frame format (data width, parity, stop bits) and bit period are configurable. Sits between the chip's command/debug logic and the TX pad. It accepts bytes through a valid/ready handshake and serialises them LSB-first with no gaps beyond one idle clock between frames.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Each frame latches its own divisor, parity mode and stop-bit count.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                               i_clock,
    input  logic                               i_rst,
    input  logic [DIV_W-1:0]                   i_div,
    input  logic [1:0]                         i_parity,
    input  logic                               i_two_stop,
    input  logic                               i_valid,
    input  logic [DATA_BITS-1:0]               i_data,
    output logic                               o_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
    output logic                               o_tx_serial,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           par_q, par_d;
    logic                 two_stop_q, two_stop_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 done_q, done_d;

    logic push, pop, full, bit_end, par_en, par_bit;

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign push    = i_valid && !full;
    assign pop     = (state_q == StIdle) && (level_q != '0);
    // div_q is never 0, so the last clock of a bit is div_q-1
    assign bit_end = (cnt_q == div_q - DIV_W'(1));
    assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_bit = (^data_q) ^ (par_q == 2'b10);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        div_d      = div_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        cnt_d      = bit_end ? '0 : cnt_q + DIV_W'(1);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (pop) begin
                    data_d     = mem_q[rd_ptr_q];
                    div_d      = (i_div == '0) ? DIV_W'(1) : i_div;
                    par_d      = i_parity;
                    two_stop_d = i_two_stop;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = par_en ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    if (!two_stop_q || idx_q == IDX_W'(1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_tx_serial = 1'b1;
        unique case (state_q)
            StStart:  o_tx_serial = 1'b0;
            StData:   o_tx_serial = data_q[idx_q];
            StParity: o_tx_serial = par_bit;
            default:  o_tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            div_q      <= DIV_W'(1);
            par_q      <= 2'b00;
            two_stop_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_q     <= data_d;
            div_q      <= div_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    assign o_ready = !full;
    assign o_level = level_q;
    assign o_busy  = (state_q != StIdle);
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected line waveforms,
// a negedge monitor captures each frame from start bit to o_done and compares.
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;   // bit i = i-th bit on the line (start first)
        int          div;    // effective clocks per bit
        int          clocks; // total frame length
        int          gap;    // idle clocks before start; 0 = don't care
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd4;
    logic [1:0]  parity = 2'b00;
    logic        two_stop = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        ready, tx, busy, done;
    logic [2:0]  level;

    logic [15:0] div5 = 16'd0;
    logic        valid5 = 1'b0;
    logic [4:0]  data5 = 5'h00;
    logic        ready5, tx5, busy5, done5;
    logic [2:0]  level5;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit           cap_on   [2] = '{1'b0, 1'b0};
    logic [127:0] cap_vec  [2];
    int           cap_len  [2] = '{0, 0};
    bit           busy_bad [2] = '{1'b0, 1'b0};
    int           idle_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .i_clock(clk), .i_rst(rst), .i_div(div), .i_parity(parity),
        .i_two_stop(two_stop), .i_valid(valid), .i_data(data), .o_ready(ready),
        .o_level(level), .o_tx_serial(tx), .o_busy(busy), .o_done(done)
    );

    uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
        .i_clock(clk), .i_rst(rst), .i_div(div5), .i_parity(2'b00),
        .i_two_stop(1'b0), .i_valid(valid5), .i_data(data5), .o_ready(ready5),
        .o_level(level5), .o_tx_serial(tx5), .o_busy(busy5), .o_done(done5)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] b, input int dv, input int clks,
                                input int gp);
        exp_t e;
        e.bits = b;
        e.div = dv;
        e.clocks = clks;
        e.gap = gp;
        return e;
    endfunction

    task automatic mon_step(input int k, input logic line, input logic dn,
                            input logic bsy);
        exp_t e;
        logic [127:0] ev;
        int qs;
        qs = (k == 0) ? q0.size() : q1.size();
        if (rst) begin
            cap_on[k] = 1'b0;
            idle_cnt[k] = 0;
            return;
        end
        if (cap_on[k]) begin
            if (dn) begin
                cap_on[k] = 1'b0;
                idle_cnt[k] = 1;
                check($sformatf("busy_at_done%0d", k), bsy, 1'b0);
                check($sformatf("frame_expected%0d", k), qs != 0, 1'b1);
                if (qs != 0) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    ev = '0;
                    for (int i = 0; i < e.clocks && i < 128; i++) ev[i] = e.bits[i / e.div];
                    check($sformatf("frame_len%0d", k), cap_len[k], e.clocks);
                    check($sformatf("frame_wave%0d", k), cap_vec[k], ev);
                    check($sformatf("busy_in_frame%0d", k), busy_bad[k], 1'b0);
                end
            end else begin
                if (cap_len[k] < 128) cap_vec[k][cap_len[k]] = line;
                cap_len[k]++;
                if (!bsy) busy_bad[k] = 1'b1;
            end
        end else if (dn) begin
            check($sformatf("spurious_done%0d", k), dn, 1'b0);
        end else if (!line) begin
            cap_on[k] = 1'b1;
            cap_vec[k] = '0;
            cap_vec[k][0] = line;
            cap_len[k] = 1;
            busy_bad[k] = !bsy;
            if (qs != 0) begin
                e = (k == 0) ? q0[0] : q1[0];
                if (e.gap != 0) check($sformatf("gap%0d", k), idle_cnt[k], e.gap);
            end
        end else begin
            idle_cnt[k]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx, done, busy);
        mon_step(1, tx5, done5, busy5);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        valid = 1'b1;
        data = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy || busy5) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_in_time"}, n < budget, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_ready", ready, 1'b1);
        rst = 1'b0;
        tick();

        // 8N1, 0xA5, div 4: 10 bits x 4 = 40 clocks
        q0.push_back(mk(16'b1_10100101_0, 4, 40, 0));
        push(8'hA5);
        check("push_level", level, 3'd1);
        check("pre_pop_busy", busy, 1'b0);
        tick();
        check("post_pop_level", level, 3'd0);
        check("post_pop_busy", busy, 1'b1);
        check("start_bit", tx, 1'b0);
        wait_done("8n1", 200);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        div = 16'd2;
        parity = 2'b01;
        q0.push_back(mk(16'b1_1_00000111_0, 2, 22, 0));
        push(8'h07);
        wait_done("par_even", 200);
        parity = 2'b10;
        q0.push_back(mk(16'b1_0_00000111_0, 2, 22, 0));
        push(8'h07);
        wait_done("par_odd", 200);
        parity = 2'b11;
        q0.push_back(mk(16'b1_00000111_0, 2, 20, 0));
        push(8'h07);
        wait_done("par_none", 200);

        // Two stop bits; a mid-frame divisor change must wait for the next frame
        parity = 2'b00;
        div = 16'd3;
        two_stop = 1'b1;
        q0.push_back(mk(16'b11_00000000_0, 3, 33, 0));
        push(8'h00);
        repeat (5) tick();
        div = 16'd8;
        wait_done("two_stop_div3", 200);
        q0.push_back(mk(16'b11_00000000_0, 8, 88, 0));
        push(8'h00);
        wait_done("two_stop_div8", 300);

        // FIFO full: 5 writes during a frame, only 4 fit
        div = 16'd2;
        two_stop = 1'b0;
        q0.push_back(mk(16'b1_00111100_0, 2, 20, 0));
        push(8'h3C);
        tick();
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(mk({7'b0, 1'b1, 8'(i), 1'b0}, 2, 20, 1));
        end
        for (int i = 1; i <= 5; i++) begin
            valid = 1'b1;
            data = 8'(i);
            if (i == 5) begin
                check("full_level", level, 3'd4);
                check("full_ready", ready, 1'b0);
            end
            tick();
        end
        valid = 1'b0;
        check("full_level_after", level, 3'd4);
        wait_done("fifo_full", 400);

        // Reset during data bit 3 with two words still queued
        div = 16'd4;
        push(8'h55);
        push(8'h66);
        push(8'h77);
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check("busy_before_reset", busy, 1'b1);
        repeat (15) tick();
        check("level_before_reset", level, 3'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_level", level, 3'd0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (150) tick();
        check("quiet_after_reset", busy, 1'b0);

        // 5-bit instance with divisor 0: every bit one clock, 7-clock frame
        q1.push_back(mk(16'b1_11111_0, 1, 7, 0));
        valid5 = 1'b1;
        data5 = 5'h1F;
        tick();
        valid5 = 1'b0;
        wait_done("div0_5bit", 100);

        repeat (5) tick();
        check("no_open_capture", cap_on[0] | cap_on[1], 1'b0);
        check("no_pending_frames", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
